// File: rtl/scan_pkg.sv
// Shared types for the frame scan address sequencer.
// Orientation codes, axis directions, scan config and FSM states.
package scan_pkg;

  typedef enum logic [2:0] {
    ORI_0,
    ORI_45,
    ORI_90,
    ORI_135,
    ORI_180,
    ORI_225,
    ORI_270,
    ORI_315
  } orient_t;

  typedef enum logic {
    UP,
    DOWN
  } scan_dir_t;

  typedef struct packed {
    logic      swap;
    scan_dir_t row_dir;
    scan_dir_t col_dir;
  } scan_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // swap=1 makes row the fast axis
  function automatic scan_cfg_t decode_orient(orient_t o);
    scan_cfg_t c;
    c = '{swap: 1'b0, row_dir: UP, col_dir: UP};
    unique case (o)
      ORI_0:   c = '{swap: 1'b0, row_dir: UP,   col_dir: UP};
      ORI_45:  c = '{swap: 1'b1, row_dir: UP,   col_dir: UP};
      ORI_90:  c = '{swap: 1'b1, row_dir: UP,   col_dir: DOWN};
      ORI_135: c = '{swap: 1'b1, row_dir: DOWN, col_dir: UP};
      ORI_180: c = '{swap: 1'b0, row_dir: DOWN, col_dir: DOWN};
      ORI_225: c = '{swap: 1'b1, row_dir: DOWN, col_dir: DOWN};
      ORI_270: c = '{swap: 1'b0, row_dir: UP,   col_dir: DOWN};
      ORI_315: c = '{swap: 1'b0, row_dir: DOWN, col_dir: UP};
      default: c = '{swap: 1'b0, row_dir: UP,   col_dir: UP};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// One scan axis: loads its direction-dependent start value,
// steps toward the terminal value, flags when terminal.
module scan_axis_counter
  import scan_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  scan_dir_t     dir,
  output logic [AW-1:0] count,
  output logic          at_term
);

  localparam logic [AW-1:0] MAXV = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (dir == DOWN) ? MAXV : '0;
    end else if (step) begin
      count <= (dir == DOWN) ? count - ONE : count + ONE;
    end
  end

  assign at_term = (dir == DOWN) ? (count == '0)
                                 : (count == MAXV);

endmodule

// File: rtl/scan_addr_gen.sv
// Walks a DIM x DIM frame in one of 8 scan orders and
// emits one {row,col} address per accepted beat.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter  int DIM = 1024,
  localparam int AW  = $clog2(DIM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      orient,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [2*AW-1:0] out_addr,
  output logic [AW-1:0]   out_row,
  output logic [AW-1:0]   out_col,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  state_t    state, state_nx;
  orient_t   ori_q;
  scan_cfg_t cfg_in, cfg_q, cfg;

  logic row_term, col_term;
  logic row_load, col_load;
  logic row_step, col_step;
  logic acc, fire, fast_term;
  logic fast_step, wrap;

  assign cfg_in = decode_orient(orient_t'(orient));
  assign cfg_q  = decode_orient(ori_q);
  // the load in IDLE must see the incoming orientation
  assign cfg    = (state == IDLE) ? cfg_in : cfg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ori_q <= ORI_0;
    end else begin
      state <= state_nx;
      if (acc) ori_q <= orient_t'(orient);
    end
  end

  always_comb begin
    state_nx  = state;
    acc       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        acc = start;
        if (start) state_nx = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = row_term & col_term;
        if (out_ready && out_last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fire      = out_valid & out_ready;
  assign fast_term = cfg.swap ? row_term : col_term;
  assign fast_step = fire & ~out_last & ~fast_term;
  assign wrap      = fire & ~out_last & fast_term;

  assign row_load = acc | (wrap & cfg.swap);
  assign col_load = acc | (wrap & ~cfg.swap);
  assign row_step = cfg.swap ? fast_step : wrap;
  assign col_step = cfg.swap ? wrap : fast_step;

  scan_axis_counter #(.AW(AW)) u_row (
    .clk     (clk),
    .reset   (reset),
    .load    (row_load),
    .step    (row_step),
    .dir     (cfg.row_dir),
    .count   (out_row),
    .at_term (row_term)
  );

  scan_axis_counter #(.AW(AW)) u_col (
    .clk     (clk),
    .reset   (reset),
    .load    (col_load),
    .step    (col_step),
    .dir     (cfg.col_dir),
    .count   (out_col),
    .at_term (col_term)
  );

  assign out_addr = {out_row, out_col};

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen at DIM=4 with a
// nested-loop reference model and random backpressure.
module tb_scan_addr_gen;

  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    orient = 3'd0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [2*AW-1:0] out_addr;
  logic [AW-1:0] out_row, out_col;
  logic          out_last, busy, done;

  scan_addr_gen #(.DIM(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .orient    (orient),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   beats   = 0;
  int   ndone   = 0;
  int   rmode   = 0;

  // orientation table: bit i describes orientation i
  logic [7:0] t_swap  = 8'b0010_1110;
  logic [7:0] t_rdown = 8'b1011_1000;
  logic [7:0] t_cdown = 8'b0111_0100;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic build(input int o);
    exp_t e;
    int ri, ci, r, c;
    for (int s = 0; s < D; s++) begin
      for (int f = 0; f < D; f++) begin
        ri = t_swap[o] ? f : s;
        ci = t_swap[o] ? s : f;
        r  = t_rdown[o] ? D - 1 - ri : ri;
        c  = t_cdown[o] ? D - 1 - ci : ci;
        e.addr = 4'(r * D + c);
        e.row  = 2'(r);
        e.col  = 2'(c);
        e.last = (s == D - 1) && (f == D - 1);
        sb.push_back(e);
      end
    end
  endtask

  // ready driver: 0 always, 1 random, 2 stall after beat 2
  initial begin
    int held;
    held = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) begin
        out_ready = ($urandom_range(0, 2) != 0);
        held = 0;
      end else if (rmode == 2 && beats == 2 && held < 3) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = 1'b1;
        if (rmode != 2) held = 0;
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    bit sv, sl, xd;
    logic [3:0] sa;
    sv = 0; sl = 0; xd = 0; sa = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sv = 0;
        xd = 0;
      end else begin
        if (sv) begin
          chk(out_valid && out_addr == sa && out_last == sl,
              "stall_hold", int'(out_addr), int'(sa));
        end
        if (xd || done) begin
          chk(done == xd && busy, "done_pulse",
              int'(done), int'(xd));
        end
        xd = 0;
        if (done) ndone++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(0, "unexpected_beat", int'(out_addr), -1);
          end else begin
            e = sb.pop_front();
            chk(out_addr == e.addr, "addr",
                int'(out_addr), int'(e.addr));
            chk(out_row == e.row && out_col == e.col, "rowcol",
                int'({out_row, out_col}), int'({e.row, e.col}));
            chk(out_last == e.last, "last",
                int'(out_last), int'(e.last));
            xd = e.last;
          end
          beats++;
        end
        sv = out_valid && !out_ready;
        sa = out_addr;
        sl = out_last;
      end
    end
  end

  task automatic run_frame(input int o, input bit inject);
    int b0, d0;
    bit seen;
    build(o);
    b0 = beats;
    d0 = ndone;
    seen = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    orient = 3'(o);
    @(posedge clk); #1;
    start  = 1'b0;
    orient = 3'($urandom_range(0, 7));
    chk(out_valid == 1'b1, "latency", int'(out_valid), 1);
    chk(busy == 1'b1, "busy_run", int'(busy), 1);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && c == 3) begin
        start  = 1'b1;
        orient = 3'd7;
      end
      if (done) begin
        seen = 1;
        if (inject) begin
          start  = 1'b1;
          orient = 3'd7;
        end
      end
    end
    chk(seen, "done_timeout", int'(seen), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk(!busy && !out_valid, "idle_after_done",
        int'({busy, out_valid}), 0);
    chk(beats - b0 == D * D, "beat_count", beats - b0, D * D);
    chk(ndone - d0 == 1, "done_count", ndone - d0, 1);
    chk(sb.size() == 0, "sb_empty", sb.size(), 0);
  endtask

  task automatic reset_midframe();
    int b0;
    build(0);
    b0 = beats;
    @(posedge clk); #1;
    start  = 1'b1;
    orient = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && beats - b0 < 5; c++) begin
      @(posedge clk); #1;
    end
    chk(beats - b0 >= 5, "reset_wait", beats - b0, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk(!out_valid && !busy, "rst_mid_ctl",
        int'({out_valid, busy}), 0);
    chk(out_row == 0 && out_col == 0, "rst_mid_cnt",
        int'({out_row, out_col}), 0);
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(!out_valid && !out_last, "rst_valid",
        int'({out_valid, out_last}), 0);
    chk(!busy && !done, "rst_busy", int'({busy, done}), 0);
    chk(out_addr == 0, "rst_addr", int'(out_addr), 0);

    rmode = 0;
    run_frame(0, 0);
    run_frame(4, 0);
    run_frame(5, 0);
    rmode = 2;
    run_frame(2, 0);
    rmode = 0;
    run_frame(0, 1);
    reset_midframe();
    run_frame(4, 0);
    rmode = 1;
    for (int r = 0; r < 16; r++) run_frame(int'($urandom_range(0, 7)), 0);
    for (int o = 0; o < 8; o++) run_frame(o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
Frame read-address sequencer that sits directly downstream of the per-orientation scan counters. It replaces their discrete clear/enable control with one block that walks a DIM x DIM frame buffer in one of 8 orientation-dependent scan orders. It emits one {row,col} pixel address per accepted beat over a valid/ready handshake to the frame-buffer read port. Descending axes count DIM-1 down to 0, matching the existing 180/225 counter behaviour.

Parameters:
DIM, 1024, frame width = height in pixels; power of two, >= 2
AW, $clog2(DIM), row/column index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  single-cycle frame request; sampled only in IDLE
orient  in  3  orientation code; latched on accepted start
out_ready  in  1  downstream accepts the current beat
out_valid  out  1  out_addr/out_row/out_col/out_last are valid
out_addr  out  2*AW  pixel address = {row, col} (= row*DIM + col)
out_row  out  AW  current row index
out_col  out  AW  current column index
out_last  out  1  current beat is the final address of the frame
busy  out  1  high from accepted start until DONE is exited
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: state IDLE; out_valid, out_last, busy and done = 0; row and col counters = 0; out_addr = 0; latched orient = 0. Reset overrides every other input in any state, including mid-frame.
- Orientation decode, as (swap, row_dir, col_dir). The fast axis is col when swap=0 and row when swap=1.
  - 0 (0 deg): 0, up, up
  - 1 (45 deg): 1, up, up
  - 2 (90 deg): 1, up, down
  - 3 (135 deg): 1, down, up
  - 4 (180 deg): 0, down, down
  - 5 (225 deg): 1, down, down
  - 6 (270 deg): 0, up, down
  - 7 (315 deg): 0, down, up
- Axis start and terminal values: an up axis starts at 0 and ends at DIM-1. A down axis starts at DIM-1 and ends at 0.
- FSM states and transitions:
  - IDLE: on start, latch orient, load both counters to their start values, set busy=1, go to RUN. Latency is start at cycle t -> out_valid=1 at t+1 with the first address.
  - RUN: out_valid=1. A beat transfers when out_valid && out_ready.
    - On transfer with the fast axis not terminal: the fast axis steps by one.
    - On transfer with the fast axis terminal: the fast axis reloads its start value and the slow axis steps by one.
    - On transfer with both axes terminal: out_last=1 on that beat, go to DONE. Counters do not advance and there is no wrap into a second frame.
  - DONE: out_valid=0, done=1 for exactly one cycle, busy stays 1 in this cycle, then go to IDLE.
- Stall: with out_valid=1 and out_ready=0, all outputs hold stable. There is no skip and no duplicate beat.
- out_last is combinational on counter state: both axes at terminal while in RUN.
- start while busy, including in DONE, is ignored. A change of orient after start has no effect on the current frame.
- Exactly DIM*DIM beats are transferred per frame.
- Counters are modulo-free. Stepping only occurs below terminal, so no arithmetic wrap ever happens.

Decomposition:
- Package scan_pkg: orient_t enum (ORI_0 .. ORI_315), scan_dir_t {UP, DOWN}, struct scan_cfg_t {swap, row_dir, col_dir}, function decode_orient(orient_t) returning scan_cfg_t, FSM state enum {IDLE, RUN, DONE}.
- Sub-module scan_axis_counter, instantiated twice (row, col):
  - Ports: clk, reset, load, step, dir, count[AW-1:0], at_term.
  - load sets the start value for dir; step does +1 or -1; load wins over step.

Test Plan:
- DIM=4, orient=0, out_ready=1 -> out_addr 0,1,2,...,15 on consecutive cycles starting one cycle after start; out_last on 15; done the cycle after; busy low the cycle after done.
- DIM=4, orient=4 -> out_addr 15,14,...,0; out_row/out_col go (3,3),(3,2),...,(0,0); out_last on addr 0.
- DIM=4, orient=5 -> out_addr 15,11,7,3,14,10,6,2,13,...,0; out_last on 0; 16 beats total.
- DIM=4, orient=2, out_ready low for 3 cycles after beat 2 -> beat-2 address (row 2, col 3 = 11) held stable for 3 cycles, then sequence resumes; 16 beats, no skip or duplicate.
- start pulsed with orient=7 during RUN of an orient=0 frame and during DONE -> ignored; sequence and done count are unchanged.
- reset asserted at beat 5 of a frame -> next cycle out_valid=0, busy=0, row=col=0; new start with orient=4 gives a full 16-beat frame starting at 15.
